// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants, PC-source encoding and address helpers.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_EX,
    SEL_HOLD,
    SEL_ID,
    SEL_SEQ
  } pc_sel_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// Keeps the instruction in ID stable across multi-cycle stalls and selects what ID sees.
module if_hold_buffer
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            ex_redirect_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] imem_dout_i,
  output logic [XLEN-1:0] inst_o
);

  logic [XLEN-1:0] hold_q, hold_d;
  logic            hold_v_q, hold_v_d;

  // Capture on the first stalled cycle: IMEM data is only trustworthy while en was high.
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    if (ex_redirect_i) begin
      hold_v_d = 1'b0;
    end else if (stall_i && !hold_v_q) begin
      hold_d   = imem_dout_i;
      hold_v_d = 1'b1;
    end else if (!stall_i) begin
      hold_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q   <= NOP_INST;
      hold_v_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  assign inst_o = !valid_i ? NOP_INST : (hold_v_q ? hold_q : imem_dout_i);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM and feeds inst/pc/valid to ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            id_redirect,
  input  logic [XLEN-1:0] id_redirect_pc,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_dout,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  pc_sel_e         pc_sel;

  always_comb begin
    if (rst)              pc_sel = SEL_RESET;
    else if (ex_redirect) pc_sel = SEL_EX;
    else if (stall)       pc_sel = SEL_HOLD;
    else if (id_redirect) pc_sel = SEL_ID;
    else                  pc_sel = SEL_SEQ;
  end

  always_comb begin
    pc_d = pc_q + 32'd4;
    unique case (pc_sel)
      SEL_RESET: pc_d = RESET_PC;
      SEL_EX:    pc_d = ex_redirect_pc;
      SEL_HOLD:  pc_d = pc_q;
      SEL_ID:    pc_d = id_redirect_pc;
      SEL_SEQ:   pc_d = pc_q + 32'd4;
      default:   pc_d = pc_q + 32'd4;
    endcase
    pc_d = word_align(pc_d);
  end

  // The rst cycle itself reads RESET_PC, so the slot after reset is already a real fetch.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    valid_q <= 1'b1;
  end

  assign imem_addr = pc_d;
  assign imem_en   = rst | ex_redirect | ~stall;
  assign id_pc     = pc_q;
  assign id_valid  = valid_q & ~ex_redirect & ~rst;

  if_hold_buffer #(
    .NOP_INST(NOP_INST)
  ) u_hold (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .ex_redirect_i (ex_redirect),
    .valid_i       (id_valid),
    .imem_dout_i   (imem_dout),
    .inst_o        (id_inst)
  );

endmodule
